// File: rtl/weight_readout.sv
// ============================================================================
// weight_readout : snapshots hidden/output weights and streams them out as
// bytes over valid/ready. Optional trailing checksum byte under the macro
// WEIGHT_READOUT_CHECKSUM_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module weight_readout #(
  parameter int N_HIDDEN = 2,
  parameter int N_IN     = 4,
  parameter int W_W      = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         req_i,
  input  logic                         b_pass_i,
  input  logic [N_HIDDEN*N_IN*W_W-1:0] hn_weights_i,
  input  logic [N_HIDDEN*W_W-1:0]      on_weights_i,
  output logic [7:0]                   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o,
  output logic                         busy_o
);

  localparam int NB = N_HIDDEN*N_IN + N_HIDDEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
`ifdef WEIGHT_READOUT_CHECKSUM_EN
    S_SEND = 2'd2,
    S_CSUM = 2'd3
`else
    S_SEND = 2'd2
`endif
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_load;
  logic               w_last_byte;
  logic [3:0]         r_idx;
  logic [NB*W_W-1:0]  r_bank;

  assign w_last_byte = (r_idx == 4'(NB-1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i && en_i) begin
          if (!b_pass_i) begin
            w_next = S_SEND;
            w_load = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!b_pass_i) begin
          w_next = S_SEND;
          w_load = 1'b1;
        end
      end
      S_SEND: begin
        if (ready_i && w_last_byte) begin
`ifdef WEIGHT_READOUT_CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_IDLE;
`endif
        end
      end
`ifdef WEIGHT_READOUT_CHECKSUM_EN
      S_CSUM: begin
        if (ready_i) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Bank byte order equals stream order: hidden weights low, output weights high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bank <= '0;
      r_idx  <= 4'd0;
    end else if (w_load) begin
      r_bank <= {on_weights_i, hn_weights_i};
      r_idx  <= 4'd0;
    end else if (r_state == S_SEND && ready_i && !w_last_byte) begin
      r_idx  <= r_idx + 4'd1;
    end
  end

`ifdef WEIGHT_READOUT_CHECKSUM_EN
  logic [7:0] w_csum;

  always_comb begin
    w_csum = 8'd0;
    for (int i = 0; i < NB; i++) begin
      w_csum = w_csum + r_bank[i*8 +: 8];
    end
  end

  always_comb begin
    data_o  = 8'd0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    if (r_state == S_SEND) begin
      data_o  = r_bank[r_idx*8 +: 8];
      valid_o = 1'b1;
    end else if (r_state == S_CSUM) begin
      data_o  = w_csum;
      valid_o = 1'b1;
      last_o  = 1'b1;
    end
  end
`else
  always_comb begin
    data_o  = 8'd0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    if (r_state == S_SEND) begin
      data_o  = r_bank[r_idx*8 +: 8];
      valid_o = 1'b1;
      last_o  = w_last_byte;
    end
  end
`endif

  assign busy_o = (r_state != S_IDLE);

endmodule

`default_nettype wire
